// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-master command engine: command FIFO feeding a two-slot address/data pipeline.
// Optional misaligned-command rejection is enabled by defining AHB_CMD_MASTER_ALIGN_CHECK_EN.
module ahb_cmd_master #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_hclk,
  input  logic              i_hreset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [2:0]        i_cmd_size,
  input  logic [31:0]       i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_write,
  output logic              o_busy,
  output logic              o_hsel,
  output logic [ADDR_W-1:0] o_haddr,
  output logic [1:0]        o_htrans,
  output logic              o_hwrite,
  output logic [2:0]        o_hsize,
  output logic [3:0]        o_hprot,
  output logic [31:0]       o_hwdata,
  input  logic [31:0]       i_hrdata,
  input  logic              i_hready,
  input  logic              i_hresp
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CMD_W = ADDR_W + 36;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {StIdle, StActive, StErr1} state_e;

  state_e             r_state;
  logic [CMD_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               r_rdy_en;

  logic               r_aph_vld;
  logic               r_aph_bad;
  logic               r_aph_write;
  logic [31:0]        r_aph_wdata;
  logic               r_dph_vld;
  logic               r_dph_bad;
  logic               r_dph_write;

  logic [1:0]         r_htrans;
  logic               r_hsel;
  logic [ADDR_W-1:0]  r_haddr;
  logic               r_hwrite;
  logic [2:0]         r_hsize;
  logic [31:0]        r_hwdata;
  logic               r_rsp_vld;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_rsp_write;

  logic               w_push;
  logic               w_pop;
  logic               w_fifo_ne;
  logic [CMD_W-1:0]   w_head;
  logic               w_head_write;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [2:0]         w_head_size;
  logic [31:0]        w_head_wdata;
  logic               w_head_bad;

  assign w_fifo_ne    = (r_count != '0);
  assign o_cmd_ready  = r_rdy_en && (r_count != FULL_CNT);
  assign w_push       = i_cmd_valid && o_cmd_ready;
  // The head only moves into the address slot on a normal (non-error) pipeline advance.
  assign w_pop        = i_hready && (r_state != StErr1) && w_fifo_ne;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_write = w_head[CMD_W-1];
  assign w_head_addr  = w_head[CMD_W-2 -: ADDR_W];
  assign w_head_size  = w_head[34:32];
  assign w_head_wdata = w_head[31:0];

`ifdef AHB_CMD_MASTER_ALIGN_CHECK_EN
  assign w_head_bad = ((w_head_size == 3'b001) && w_head_addr[0]) ||
                      ((w_head_size == 3'b010) && (w_head_addr[1:0] != 2'b00)) ||
                      (w_head_size > 3'b010);
`else
  assign w_head_bad = 1'b0;
`endif

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_hclk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_cmd_write, i_cmd_addr, i_cmd_size, i_cmd_wdata};
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state     <= StIdle;
      r_aph_vld   <= 1'b0;
      r_aph_bad   <= 1'b0;
      r_aph_write <= 1'b0;
      r_aph_wdata <= '0;
      r_dph_vld   <= 1'b0;
      r_dph_bad   <= 1'b0;
      r_dph_write <= 1'b0;
      r_htrans    <= HTRANS_IDLE;
      r_hsel      <= 1'b0;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= 3'b000;
      r_hwdata    <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_write <= 1'b0;
    end else begin
      r_rsp_vld <= 1'b0;
      unique case (r_state)
        StIdle, StActive: begin
          if (r_state == StIdle) begin
            if (i_hready && w_fifo_ne) r_state <= StActive;
          end else if (!r_aph_vld && !r_dph_vld && !w_fifo_ne) begin
            r_state <= StIdle;
          end
          if (i_hready) begin
            if (r_dph_vld) begin
              r_rsp_vld   <= 1'b1;
              r_rsp_write <= r_dph_write;
              r_rsp_err   <= r_dph_bad || i_hresp;
              r_rsp_rdata <= (r_dph_write || r_dph_bad) ? '0 : i_hrdata;
            end
            r_dph_vld   <= r_aph_vld;
            r_dph_bad   <= r_aph_bad;
            r_dph_write <= r_aph_write;
            if (r_aph_vld && !r_aph_bad && r_aph_write) r_hwdata <= r_aph_wdata;
            if (w_fifo_ne) begin
              r_aph_vld   <= 1'b1;
              r_aph_bad   <= w_head_bad;
              r_aph_write <= w_head_write;
              r_aph_wdata <= w_head_wdata;
              r_htrans    <= w_head_bad ? HTRANS_IDLE : HTRANS_NONSEQ;
              r_hsel      <= !w_head_bad;
              // A rejected command never reaches the bus, so address/control keep their last value.
              if (!w_head_bad) begin
                r_haddr  <= w_head_addr;
                r_hwrite <= w_head_write;
                r_hsize  <= w_head_size;
              end
            end else begin
              r_aph_vld <= 1'b0;
              r_htrans  <= HTRANS_IDLE;
              r_hsel    <= 1'b0;
            end
          end else if ((r_state == StActive) && i_hresp) begin
            r_htrans <= HTRANS_IDLE;
            r_hsel   <= 1'b0;
            r_state  <= StErr1;
          end
        end
        StErr1: begin
          if (i_hready) begin
            r_rsp_vld   <= r_dph_vld;
            r_rsp_write <= r_dph_write;
            r_rsp_err   <= r_dph_bad || i_hresp;
            r_rsp_rdata <= (r_dph_write || r_dph_bad) ? '0 : i_hrdata;
            r_dph_vld   <= 1'b0;
            // The cancelled address phase is replayed in place; the FIFO does not advance.
            if (r_aph_vld) begin
              r_htrans <= r_aph_bad ? HTRANS_IDLE : HTRANS_NONSEQ;
              r_hsel   <= !r_aph_bad;
            end
            r_state <= StActive;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = w_fifo_ne || r_aph_vld || r_dph_vld;
  assign o_hsel      = r_hsel;
  assign o_haddr     = r_haddr;
  assign o_htrans    = r_htrans;
  assign o_hwrite    = r_hwrite;
  assign o_hsize     = r_hsize;
  assign o_hprot     = 4'b0011;
  assign o_hwdata    = r_hwdata;
  assign o_rsp_valid = r_rsp_vld;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_write = r_rsp_write;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master; the alignment case follows AHB_CMD_MASTER_ALIGN_CHECK_EN.
module tb_ahb_cmd_master;

  logic        clk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_write;
  logic        busy;
  logic        hsel;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] b2b_addr [3] = '{16'h2000, 16'h2004, 16'h200C};
  logic [31:0] b2b_data [3] = '{32'h11, 32'h22, 32'h33};

  always #5 clk = ~clk;

  ahb_cmd_master #(
    .ADDR_W    (16),
    .FIFO_DEPTH(4)
  ) u_dut (
    .i_hclk     (clk),
    .i_hreset   (hreset),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write),
    .i_cmd_addr (cmd_addr),
    .i_cmd_size (cmd_size),
    .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_err  (rsp_err),
    .o_rsp_write(rsp_write),
    .o_busy     (busy),
    .o_hsel     (hsel),
    .o_haddr    (haddr),
    .o_htrans   (htrans),
    .o_hwrite   (hwrite),
    .o_hsize    (hsize),
    .o_hprot    (hprot),
    .o_hwdata   (hwdata),
    .i_hrdata   (hrdata),
    .i_hready   (hready),
    .i_hresp    (hresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_htrans"}, 32'(htrans), 32'h0);
    check_eq({tag, "_hsel"}, 32'(hsel), 32'h0);
    check_eq({tag, "_haddr"}, 32'(haddr), 32'h0);
    check_eq({tag, "_hwrite"}, 32'(hwrite), 32'h0);
    check_eq({tag, "_hsize"}, 32'(hsize), 32'h0);
    check_eq({tag, "_hprot"}, 32'(hprot), 32'h3);
    check_eq({tag, "_hwdata"}, hwdata, 32'h0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    check_eq({tag, "_rsp_write"}, 32'(rsp_write), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
  endtask

  initial begin
    hreset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    hrdata    = '0;
    hready    = 1'b1;
    hresp     = 1'b0;

    // Power-on reset
    repeat (3) tick();
    check_reset_outputs("por");
    hreset = 1'b0;
    tick();
    check_eq("por_ready_after", 32'(cmd_ready), 32'h1);

    // Single write
    drive_cmd(1'b1, 16'h2000, 3'b010, 32'h9);
    tick();
    cmd_valid = 1'b0;
    check_eq("wr_k_busy", 32'(busy), 32'h1);
    check_eq("wr_k_htrans", 32'(htrans), 32'h0);
    tick();
    check_eq("wr_k1_htrans", 32'(htrans), 32'h2);
    check_eq("wr_k1_hsel", 32'(hsel), 32'h1);
    check_eq("wr_k1_haddr", 32'(haddr), 32'h2000);
    check_eq("wr_k1_hwrite", 32'(hwrite), 32'h1);
    check_eq("wr_k1_hsize", 32'(hsize), 32'h2);
    check_eq("wr_k1_hprot", 32'(hprot), 32'h3);
    tick();
    check_eq("wr_k2_hwdata", hwdata, 32'h9);
    check_eq("wr_k2_htrans", 32'(htrans), 32'h0);
    check_eq("wr_k2_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check_eq("wr_k3_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("wr_k3_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("wr_k3_rsp_write", 32'(rsp_write), 32'h1);
    check_eq("wr_k3_busy", 32'(busy), 32'h0);
    tick();
    check_eq("wr_k4_rsp_valid", 32'(rsp_valid), 32'h0);

    // Back-to-back writes
    for (int c = 0; c < 7; c++) begin
      if (c < 3) drive_cmd(1'b1, b2b_addr[c], 3'b010, b2b_data[c]);
      else cmd_valid = 1'b0;
      tick();
      check_eq("b2b_htrans", 32'(htrans), (c >= 1 && c <= 3) ? 32'h2 : 32'h0);
      if (c >= 1 && c <= 3) check_eq("b2b_haddr", 32'(haddr), 32'(b2b_addr[c-1]));
      if (c >= 2 && c <= 4) check_eq("b2b_hwdata", hwdata, b2b_data[c-2]);
      check_eq("b2b_rsp_valid", 32'(rsp_valid), (c >= 3 && c <= 5) ? 32'h1 : 32'h0);
    end

    // Read with two wait states, followed by a write held in the address phase
    drive_cmd(1'b0, 16'h2004, 3'b010, 32'h0);
    tick();
    drive_cmd(1'b1, 16'h2008, 3'b010, 32'h55);
    tick();
    cmd_valid = 1'b0;
    check_eq("ws_rd_htrans", 32'(htrans), 32'h2);
    check_eq("ws_rd_haddr", 32'(haddr), 32'h2004);
    check_eq("ws_rd_hwrite", 32'(hwrite), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      hready = (c == 2);
      if (c == 2) hrdata = 32'h18082704;
      check_eq("ws_hold_htrans", 32'(htrans), 32'h2);
      check_eq("ws_hold_haddr", 32'(haddr), 32'h2008);
      check_eq("ws_hold_hwrite", 32'(hwrite), 32'h1);
      check_eq("ws_hold_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    tick();
    hrdata = 32'h0;
    check_eq("ws_rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("ws_rd_rsp_rdata", rsp_rdata, 32'h18082704);
    check_eq("ws_rd_rsp_write", 32'(rsp_write), 32'h0);
    check_eq("ws_rd_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("ws_wr_hwdata", hwdata, 32'h55);
    tick();
    check_eq("ws_wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("ws_wr_rsp_write", 32'(rsp_write), 32'h1);
    check_eq("ws_wr_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    check_eq("ws_end_rsp_valid", 32'(rsp_valid), 32'h0);

    // Two-cycle ERROR on the first write; second write is cancelled then replayed
    drive_cmd(1'b1, 16'h1C00, 3'b010, 32'hA0);
    tick();
    drive_cmd(1'b1, 16'h1000, 3'b010, 32'hB0);
    tick();
    cmd_valid = 1'b0;
    check_eq("err_a_haddr", 32'(haddr), 32'h1C00);
    tick();
    check_eq("err_b_htrans", 32'(htrans), 32'h2);
    check_eq("err_b_haddr", 32'(haddr), 32'h1000);
    hresp  = 1'b1;
    hready = 1'b0;
    tick();
    check_eq("err_e1_htrans", 32'(htrans), 32'h0);
    check_eq("err_e1_hsel", 32'(hsel), 32'h0);
    check_eq("err_e1_rsp_valid", 32'(rsp_valid), 32'h0);
    hready = 1'b1;
    tick();
    hresp = 1'b0;
    check_eq("err_a_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("err_a_rsp_err", 32'(rsp_err), 32'h1);
    check_eq("err_replay_htrans", 32'(htrans), 32'h2);
    check_eq("err_replay_haddr", 32'(haddr), 32'h1000);
    tick();
    check_eq("err_b_dph_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("err_b_hwdata", hwdata, 32'hB0);
    tick();
    check_eq("err_b_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("err_b_rsp_err", 32'(rsp_err), 32'h0);

    // Misaligned word read
    tick();
    drive_cmd(1'b0, 16'h2002, 3'b010, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
`ifdef AHB_CMD_MASTER_ALIGN_CHECK_EN
    check_eq("al_htrans", 32'(htrans), 32'h0);
    check_eq("al_hsel", 32'(hsel), 32'h0);
`else
    check_eq("al_htrans", 32'(htrans), 32'h2);
    check_eq("al_haddr", 32'(haddr), 32'h2002);
`endif
    hrdata = 32'hDEADBEEF;
    tick();
    tick();
    hrdata = 32'h0;
    check_eq("al_rsp_valid", 32'(rsp_valid), 32'h1);
`ifdef AHB_CMD_MASTER_ALIGN_CHECK_EN
    check_eq("al_rsp_err", 32'(rsp_err), 32'h1);
    check_eq("al_rsp_rdata", rsp_rdata, 32'h0);
`else
    check_eq("al_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("al_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
`endif

    // Fill the FIFO behind a stalled write, then reset mid-transfer
    tick();
    for (int c = 0; c < 7; c++) begin
      drive_cmd(1'b1, 16'h3000 + 16'(4 * c), 3'b010, 32'(c));
      tick();
      if (c == 2) hready = 1'b0;
      if (c >= 5) begin
        check_eq("full_cmd_ready", 32'(cmd_ready), 32'h0);
        check_eq("full_busy", 32'(busy), 32'h1);
        check_eq("full_haddr", 32'(haddr), 32'h3004);
      end
    end
    cmd_valid = 1'b0;
    hready    = 1'b1;
    hreset    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_reset_outputs("rst");
    end
    hreset = 1'b0;
    tick();
    check_eq("rst_ready_after", 32'(cmd_ready), 32'h1);
    check_eq("rst_busy_after", 32'(busy), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("rst_no_rsp", 32'(rsp_valid), 32'h0);
      check_eq("rst_idle_htrans", 32'(htrans), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
# ahb_cmd_master

Synthesizable AHB-Lite single-master transfer engine that sits directly upstream of the APB subsystem's AHB slave port (HSEL/HADDR/HTRANS/HWDATA in, HRDATA/HREADYOUT/HRESP out). It accepts a queue of read/write commands over a valid/ready interface and issues them as pipelined single NONSEQ transfers. It returns one in-order response per command. It replaces task-driven stimulus for bring-up and for the SoC boot sequencer.

## Interface
- ADDR_W, 16, width of cmd_addr and HADDR.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.

- HCLK  in  1  single clock for all logic.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a command is accepted on a rising edge with cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  3  HSIZE value: 000, 001 or 010.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse per completed command; no backpressure.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  transfer ended with ERROR, or was rejected by the alignment check.
- rsp_write  out  1  echo of cmd_write.
- busy  out  1  FIFO non-empty or a transfer is outstanding.
- HSEL, HADDR[ADDR_W], HTRANS[2], HWRITE, HSIZE[3], HPROT[4], HWDATA[32]  out  AHB-Lite master signals.
- HRDATA[32], HREADY, HRESP  in  slave response signals (HREADY is wired from the slave's HREADYOUT).

## Operation
- Command FIFO: FIFO_DEPTH entries. cmd_ready = !full, derived from the registered count only. With the FIFO full, a simultaneous pop does not allow a push in the same cycle.
- Two pipeline slots:
  - Address-phase (APH) slot, loaded from the FIFO head.
  - Data-phase (DPH) slot, which holds the previous APH command.
  - When HREADY=1, APH→DPH and FIFO head→APH. When HREADY=0, both slots freeze and all master outputs hold.
- APH valid: HTRANS=10 (NONSEQ), HSEL=1, HADDR/HWRITE/HSIZE from the command, HPROT=0011.
- APH empty: HTRANS=00, HSEL=0; other outputs hold.
- DPH write: HWDATA = cmd_wdata, held until HREADY=1.
- DPH completion (HREADY=1): response registered for the next cycle.
  - Read: rsp_rdata = HRDATA.
  - rsp_err = HRESP.
- FSM states:
  - IDLE: both slots empty. Goes to ACTIVE when the FIFO is non-empty.
  - ACTIVE: normal pipelining. Goes to ERR1 on HRESP=1 with HREADY=0. Goes to IDLE when the slots and FIFO are empty.
  - ERR1: first error cycle. The APH command is cancelled: HTRANS forced to 00 in the next cycle and the command is kept in APH. On HREADY=1, the error response is emitted and the FSM returns to ACTIVE. The cancelled command is then re-issued as NONSEQ. Responses stay in command order.
- Reset mid-operation: FIFO flushed, slots cleared, outstanding transfer abandoned with no response.
- Reset values: HTRANS=00, HSEL=0, HADDR=0, HWRITE=0, HSIZE=000, HPROT=0011, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_write=0, busy=0, cmd_ready=0 while HRESET=1 and 1 afterwards.

## Timing
- Command accepted at edge k:
  - NONSEQ driven in cycle k+1 (FIFO and APH initially empty).
  - Data phase in k+2.
  - rsp_valid in k+3 with zero wait states.
- Latency to rsp_valid = 3 + wait states + FIFO queuing.
- Throughput: one transfer per cycle when the FIFO is kept fed and HREADY=1.
- Each slave wait state adds exactly one cycle to both slots.
- Error: HRESP=1/HREADY=0 in cycle e; HTRANS=00 in e+1; rsp_err=1 in the cycle after HREADY=1.

## Configuration
- AHB_CMD_MASTER_ALIGN_CHECK_EN
  - Defined: a command whose address is misaligned for cmd_size (half-word with addr[0]=1, or word with addr[1:0]≠0) occupies an APH slot as HTRANS=00, HSEL=0. No bus access occurs. Its response is rsp_valid with rsp_err=1 and rsp_rdata=0, in normal order, at the time a data phase would have completed. cmd_size values above 010 are treated the same way.
  - Undefined: all commands are issued unmodified; HADDR is driven as given.

## Test plan
- Reset: hold HRESET 5 cycles mid-transfer → every output at its reset value, busy=0, no rsp_valid; cmd_ready=1 one cycle after release.
- Single write: cmd_addr=0x2000, cmd_wdata=0x9, size 010 at edge k → NONSEQ/HSEL=1 with HADDR=0x2000 in k+1; HWDATA=0x9 in k+2; rsp_valid=1, rsp_err=0 in k+3.
- Back-to-back: writes to 0x2000, 0x2004, 0x200C with HREADY=1 → three consecutive NONSEQ cycles and three consecutive rsp_valid pulses, in order.
- Wait states: read 0x2004, slave holds HREADY=0 for 2 cycles then returns 0x18082704 → address and control stable throughout; rsp_rdata=0x18082704, rsp_valid two cycles later than zero-wait; FIFO fills to 4, cmd_ready=0 while stalled.
- Error: write 0x1C00 followed by a write 0x1000; slave gives a two-cycle ERROR → HTRANS=00 in the second error cycle; rsp_err=1 for the first write; 0x1000 then issued and rsp_err=0.
- Alignment (macro defined): size 010, addr 0x2002 → no NONSEQ, rsp_err=1. Same stimulus with the macro undefined → NONSEQ with HADDR=0x2002.
